dtc_seq_eval: RTL and testbench
===============================

DTC_SEQ_EVAL -- requirements
Module: dtc_seq_eval

Interface
REQ-001 Parameter N_FEAT, default 11: feature-vector width in bits.
REQ-002 Parameter DEPTH, default 4: tree depth; 2^DEPTH-1 internal nodes, 2^DEPTH leaves.
REQ-003 Derived constants FIDX_W = clog2(N_FEAT) and ADDR_W = DEPTH+1 SHALL be computed in the package, never set by the instantiator.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  feature vector offered.
REQ-007 in_ready  output  1  block can accept a vector.
REQ-008 inp  input  N_FEAT  feature vector.
REQ-009 out_valid  output  1  class result held.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 outp  output  1  class bit.
REQ-012 cfg_we  input  1  table write strobe.
REQ-013 cfg_addr  input  ADDR_W  heap address: 1..2^DEPTH-1 internal node, 2^DEPTH..2^(DEPTH+1)-1 leaf.
REQ-014 cfg_data  input  FIDX_W  node feature index, or leaf class in bit 0.
REQ-015 cfg_err  output  1  one-cycle pulse on a rejected write.

Function
REQ-016 FSM states: IDLE, WALK, DONE.
REQ-017 IDLE: in_ready=1; an in_valid&in_ready cycle latches inp, sets idx=1 and lvl=0, then moves to WALK.
REQ-018 WALK, each cycle: idx <= 2*idx + inp_q[feat[idx]] and lvl <= lvl+1; after DEPTH cycles move to DONE.
REQ-019 A feature index >= N_FEAT SHALL read as bit value 0.
REQ-020 DONE: out_valid=1 and outp=leaf[idx-2^DEPTH]; outp SHALL stay stable until out_ready.
REQ-021 On out_valid&out_ready, return to IDLE; in_ready SHALL NOT be 1 in the same cycle (no bypass).
REQ-022 Latency: out_valid rises exactly DEPTH+1 cycles after the accepting edge.
REQ-023 Throughput: one vector per DEPTH+2 cycles when out_ready is held at 1.
REQ-024 cfg_we in IDLE writes the addressed entry, visible to the next accepted vector.
REQ-025 A write in WALK or DONE is dropped and pulses cfg_err.
REQ-026 A write to cfg_addr=0 is dropped and pulses cfg_err.
REQ-027 cfg_we and in_valid in the same IDLE cycle: the write completes first and the vector is accepted; the walk SHALL use the new entry.
REQ-028 in_valid outside IDLE is ignored; inp is not sampled.

Reset
REQ-029 rst_n low: state=IDLE, in_ready=0 while asserted, out_valid=0, outp=0, cfg_err=0, idx=1, lvl=0.
REQ-030 Reset clears all node feature indices and leaf classes to 0.
REQ-031 Reset mid-WALK or mid-DONE aborts the vector with no output.
REQ-032 in_ready SHALL go to 1 on the first clock edge after rst_n deasserts.

Configuration
REQ-033 Macro DTC_LEAF_IDX_EN defined: adds output out_leaf (DEPTH bits) = idx-2^DEPTH, valid with out_valid, reset 0.
REQ-034 DTC_LEAF_IDX_EN undefined: out_leaf port and its logic are absent; all other behaviour is identical.

Structure
REQ-035 Package dtc_pkg SHALL hold the state enum, FIDX_W/ADDR_W functions and heap-index helpers.
REQ-036 Sub-module dtc_node_mem SHALL hold the node and leaf register file, with one write port and one combinational read port by heap index.

Verification (N_FEAT=11, DEPTH=2; program node1=8, node2=10, node3=10, leaves 4..7 = 1,0,1,0)
REQ-037 inp=0x000 accepted -> out_valid 3 cycles later, outp=1, out_leaf=0.
REQ-038 inp=0x500 (bits 10 and 8 set) -> outp=0, out_leaf=3.
REQ-039 out_ready held 0 for 5 cycles -> outp and out_valid stable; in_ready=0 throughout.
REQ-040 cfg_we to addr 5 during WALK -> cfg_err pulses one cycle and leaf 5 is unchanged.
REQ-041 cfg_we (addr 1, data 15) with in_valid in the same cycle, inp=0x000 -> index 15 reads as 0, path goes left, outp=leaf4=1.
REQ-042 rst_n low during WALK -> no out_valid; table reads all zero; the next vector yields outp=0.

Source files
------------

// File: rtl/dtc_pkg.sv
// dtc_pkg: shared types and sizing helpers for the sequential decision-tree evaluator.
// Table layout is a 1-based heap: node i has children 2i and 2i+1, and the
// leaves sit at 2^DEPTH .. 2^(DEPTH+1)-1.
package dtc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a feature index (at least one bit).
    function automatic int fidx_w(input int n_feat);
        return (n_feat > 1) ? $clog2(n_feat) : 1;
    endfunction

    // Width of a heap address covering nodes and leaves.
    function automatic int addr_w(input int depth);
        return depth + 1;
    endfunction

    // Heap address of the leftmost leaf.
    function automatic int leaf_base(input int depth);
        return 1 << depth;
    endfunction

    // Number of heap slots, including the unused slot 0.
    function automatic int n_entries(input int depth);
        return 1 << (depth + 1);
    endfunction

endpackage

// File: rtl/dtc_node_mem.sv
// dtc_node_mem: node feature indices and leaf classes, addressed by heap index.
// One synchronous write port, one combinational read port. Slot 0 is never
// written by the parent and always reads as zero.
module dtc_node_mem
    import dtc_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int FIDX_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [addr_w(DEPTH)-1:0]   waddr,
    input  logic [FIDX_W-1:0]          wdata,
    input  logic [addr_w(DEPTH)-1:0]   raddr,
    output logic [FIDX_W-1:0]          rdata
);

    localparam int NENT = n_entries(DEPTH);

    logic [FIDX_W-1:0] mem [NENT];

    // Register file: cleared on reset so an unprogrammed tree classifies as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NENT; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dtc_seq_eval.sv
// dtc_seq_eval: walks a depth-DEPTH binary decision tree, one level per cycle,
// over a latched feature vector and presents the leaf class until taken.
// Optional feature macro: DTC_LEAF_IDX_EN adds the out_leaf port (leaf number).
module dtc_seq_eval
    import dtc_pkg::*;
#(
    parameter int N_FEAT = 11,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_FEAT-1:0]           inp,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        outp,
    input  logic                        cfg_we,
    input  logic [addr_w(DEPTH)-1:0]    cfg_addr,
    input  logic [fidx_w(N_FEAT)-1:0]   cfg_data,
    output logic                        cfg_err
`ifdef DTC_LEAF_IDX_EN
    ,
    output logic [DEPTH-1:0]            out_leaf
`endif
);

    localparam int FIDX_W = fidx_w(N_FEAT);
    localparam int ADDR_W = addr_w(DEPTH);

    state_t              state, state_nx;
    logic                rdy_en;
    logic [N_FEAT-1:0]   inp_q;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   lvl;
    logic [FIDX_W-1:0]   node_q;
    logic                fbit;
    logic                accept;
    logic                wr_ok;
    logic                wr_bad;
    logic                last_lvl;

    // Table read follows idx: a feature index while walking, the leaf class in DONE.
    dtc_node_mem #(
        .DEPTH  (DEPTH),
        .FIDX_W (FIDX_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (idx),
        .rdata (node_q)
    );

    // Indices past the feature vector read as 0 (go left).
    assign fbit     = (int'(node_q) < N_FEAT) ? inp_q[node_q] : 1'b0;
    assign last_lvl = (lvl == ADDR_W'(DEPTH - 1));
    assign accept   = in_valid && in_ready;
    // Writes are only safe while no walk is reading the table.
    assign wr_ok    = cfg_we && (state == IDLE) && (cfg_addr != '0);
    assign wr_bad   = cfg_we && !wr_ok;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and handshake outputs; in_ready only in IDLE, so no bypass from DONE.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        outp      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rdy_en;
                if (in_valid && rdy_en) state_nx = WALK;
            end
            WALK: begin
                if (last_lvl) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                outp      = node_q[0];
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: latch the vector on accept, descend one level per WALK cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en  <= 1'b0;
            inp_q   <= '0;
            idx     <= ADDR_W'(1);
            lvl     <= '0;
            cfg_err <= 1'b0;
        end else begin
            rdy_en  <= 1'b1;
            cfg_err <= wr_bad;
            if (accept) begin
                inp_q <= inp;
                idx   <= ADDR_W'(1);
                lvl   <= '0;
            end else if (state == WALK) begin
                idx <= {idx[ADDR_W-2:0], fbit};
                lvl <= lvl + ADDR_W'(1);
            end
        end
    end

`ifdef DTC_LEAF_IDX_EN
    // In DONE idx is 2^DEPTH + leaf number, so the low bits are the leaf number.
    assign out_leaf = out_valid ? idx[DEPTH-1:0] : '0;
`endif

endmodule

// File: tb/tb_dtc_seq_eval.sv
// tb_dtc_seq_eval: scoreboard bench for dtc_seq_eval (N_FEAT=11, DEPTH=2).
// Expected results come from a behavioural tree model over a shadow table.
module tb_dtc_seq_eval;

    localparam int N_FEAT = 11;
    localparam int DEPTH  = 2;
    localparam int FW     = 4;
    localparam int AW     = 3;

    typedef struct packed {
        logic             cls;
        logic [DEPTH-1:0] leaf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              cfg_we = 1'b0;
    logic [N_FEAT-1:0] inp = '0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [FW-1:0]     cfg_data = '0;
    logic              in_ready, out_valid, outp, cfg_err;
`ifdef DTC_LEAF_IDX_EN
    logic [DEPTH-1:0]  out_leaf;
`endif

    int   checks = 0;
    int   failures = 0;
    int   mtab [8];
    exp_t sb [$];

    always #5 clk = ~clk;

    dtc_seq_eval #(.N_FEAT(N_FEAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inp       (inp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outp      (outp),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err)
`ifdef DTC_LEAF_IDX_EN
        ,
        .out_leaf  (out_leaf)
`endif
    );

    // Reference tree walk over the shadow table.
    function automatic exp_t model(input logic [N_FEAT-1:0] v);
        int   idx = 1;
        exp_t e;
        for (int l = 0; l < DEPTH; l++) begin
            int f = mtab[idx];
            int b = (f < N_FEAT) ? int'(v[f]) : 0;
            idx = 2 * idx + b;
        end
        e.cls  = (mtab[idx] & 1) != 0;
        e.leaf = DEPTH'(idx - (1 << DEPTH));
        return e;
    endfunction

    // All stimulus tasks start and end on a falling edge.
    task automatic cfg_write(input int addr, input int data);
        cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = FW'(data);
        if (addr != 0) mtab[addr] = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic program_table();
        cfg_write(1, 8); cfg_write(2, 10); cfg_write(3, 10);
        cfg_write(4, 1); cfg_write(5, 0); cfg_write(6, 1); cfg_write(7, 0);
    endtask

    task automatic send(input logic [N_FEAT-1:0] v);
        int n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!in_ready) begin failures++; $display("FAIL send_timeout in_ready=%b exp=1", in_ready); end
        in_valid = 1'b1; inp = v;
        sb.push_back(model(v));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts cycles after the accepting edge; first call point is cycle 1.
    task automatic wait_valid(output int c);
        c = 1;
        while (!out_valid && c < 20) begin @(negedge clk); c++; end
    endtask

    task automatic take();
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e; int c;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, outp, cfg_err} !== 4'b0) begin
            failures++; $display("FAIL reset_outs got=%b exp=0000", {in_ready, out_valid, outp, cfg_err});
        end
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL rdy_before_edge got=%b exp=0", in_ready); end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rdy_after_edge got=%b exp=1", in_ready); end
        // Cleared table: every node tests bit 0, every leaf is class 0.
        send(11'h001);
        wait_valid(c);
        e = sb.pop_front();
        checks++;
        if (c != DEPTH + 1) begin failures++; $display("FAIL reset_lat got=%0d exp=%0d", c, DEPTH + 1); end
        checks++;
        if (outp !== e.cls) begin failures++; $display("FAIL reset_tab_cls got=%b exp=%b", outp, e.cls); end
        take();
    endtask

    task automatic test_basic();
        logic [N_FEAT-1:0] vecs [4] = '{11'h000, 11'h500, 11'h100, 11'h400};
        exp_t e; int c;
        program_table();
        checks++;
        if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_ok_err got=%b exp=0", cfg_err); end
        for (int i = 0; i < 4; i++) begin
            send(vecs[i]);
            wait_valid(c);
            e = sb.pop_front();
            checks++;
            if (c != DEPTH + 1) begin failures++; $display("FAIL basic_lat[%0d] got=%0d exp=%0d", i, c, DEPTH + 1); end
            checks++;
            if (outp !== e.cls) begin failures++; $display("FAIL basic_cls[%0d] got=%b exp=%b", i, outp, e.cls); end
`ifdef DTC_LEAF_IDX_EN
            checks++;
            if (out_leaf !== e.leaf) begin failures++; $display("FAIL basic_leaf[%0d] got=%0d exp=%0d", i, out_leaf, e.leaf); end
`endif
            out_ready = 1'b1;
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL no_bypass[%0d] got=%b exp=0", i, in_ready); end
            @(negedge clk);
            out_ready = 1'b0;
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_rdy[%0d] got=%b exp=1", i, in_ready); end
        end
    endtask

    task automatic test_hold();
        exp_t e; int c;
        send(11'h100);
        wait_valid(c);
        e = sb.pop_front();
        // Offer a different vector while stalled; it must be ignored.
        in_valid = 1'b1; inp = 11'h500;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, outp, in_ready} !== {1'b1, e.cls, 1'b0}) begin
                failures++; $display("FAIL hold[%0d] got=%b exp=%b", i, {out_valid, outp, in_ready}, {1'b1, e.cls, 1'b0});
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        take();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_release got=%b exp=0", out_valid); end
    endtask

    task automatic test_cfg_busy();
        exp_t e; int c;
        send(11'h400);
        // Now in WALK: this write must be dropped.
        cfg_we = 1'b1; cfg_addr = 3'd5; cfg_data = 4'd1;
        @(negedge clk);
        cfg_we = 1'b0;
        checks++;
        if (cfg_err !== 1'b1) begin failures++; $display("FAIL busy_err got=%b exp=1", cfg_err); end
        @(negedge clk);
        checks++;
        if (cfg_err !== 1'b0) begin failures++; $display("FAIL busy_err_pulse got=%b exp=0", cfg_err); end
        wait_valid(c);
        e = sb.pop_front();
        checks++;
        if (outp !== e.cls) begin failures++; $display("FAIL busy_cls got=%b exp=%b", outp, e.cls); end
        take();
        send(11'h400);
        wait_valid(c);
        e = sb.pop_front();
        checks++;
        if (outp !== e.cls) begin failures++; $display("FAIL leaf5_kept got=%b exp=%b", outp, e.cls); end
        take();
        cfg_write(0, 5);
        checks++;
        if (cfg_err !== 1'b1) begin failures++; $display("FAIL addr0_err got=%b exp=1", cfg_err); end
    endtask

    task automatic test_same_cycle();
        int addrs [2] = '{1, 2};
        int datas [2] = '{15, 9};
        logic [N_FEAT-1:0] vecs [2] = '{11'h000, 11'h400};
        exp_t e; int c;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_addr = AW'(addrs[i]); cfg_data = FW'(datas[i]);
            mtab[addrs[i]] = datas[i];
            in_valid = 1'b1; inp = vecs[i];
            sb.push_back(model(vecs[i]));
            @(negedge clk);
            cfg_we = 1'b0; in_valid = 1'b0;
            wait_valid(c);
            e = sb.pop_front();
            checks++;
            if (outp !== e.cls) begin failures++; $display("FAIL same_cyc_cls[%0d] got=%b exp=%b", i, outp, e.cls); end
`ifdef DTC_LEAF_IDX_EN
            checks++;
            if (out_leaf !== e.leaf) begin failures++; $display("FAIL same_cyc_leaf[%0d] got=%0d exp=%0d", i, out_leaf, e.leaf); end
`endif
            take();
        end
        cfg_write(1, 8);
        cfg_write(2, 10);
    endtask

    task automatic test_reset_mid();
        exp_t e; int c; int seen = 0;
        send(11'h500);
        rst_n = 1'b0;
        sb.delete();
        for (int i = 0; i < 8; i++) mtab[i] = 0;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin failures++; $display("FAIL mid_rst_outs got=%b exp=00", {out_valid, in_ready}); end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin @(negedge clk); if (out_valid) seen++; end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL mid_rst_abort got=%0d exp=0", seen); end
        // Leaf 4 was programmed to 1; after reset it must read 0.
        send(11'h000);
        wait_valid(c);
        e = sb.pop_front();
        checks++;
        if (outp !== e.cls) begin failures++; $display("FAIL mid_rst_cls got=%b exp=%b", outp, e.cls); end
        take();
    endtask

    task automatic test_back_to_back();
        logic [N_FEAT-1:0] vecs [6] = '{11'h000, 11'h500, 11'h100, 11'h400, 11'h7ff, 11'h2aa};
        int acc [$];
        int k = 0, got = 0;
        bit took;
        exp_t e;
        program_table();
        in_valid = 1'b1; inp = vecs[0]; out_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
            took = 1'b0;
            if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL b2b_extra got=out_valid exp=none");
                end else begin
                    e = sb.pop_front();
                    if (outp !== e.cls) begin failures++; $display("FAIL b2b_cls[%0d] got=%b exp=%b", got, outp, e.cls); end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(inp)); acc.push_back(cyc); k++; took = 1'b1;
            end
            @(posedge clk); #1;
            if (took) begin
                if (k < 6) inp = vecs[k];
                else in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (got != 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", got); end
        for (int i = 1; i < acc.size(); i++) begin
            checks++;
            if (acc[i] - acc[i-1] != DEPTH + 2) begin
                failures++; $display("FAIL b2b_period[%0d] got=%0d exp=%0d", i, acc[i] - acc[i-1], DEPTH + 2);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mtab[i] = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_hold();
        test_cfg_busy();
        test_same_cycle();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
